// File: rtl/pause_sequencer_pkg.sv
// Shared types and defaults for the frame-aligned pause controller.
package pause_sequencer_pkg;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    WAIT_VBL   = 3'd1,
    HALTING    = 3'd2,
    PAUSED     = 3'd3,
    RESUME_VBL = 3'd4
  } state_e;

  // 10 s at 12 MHz
  localparam int unsigned DIM_CYCLES_DEFAULT = 32'd120000000;

endpackage

// File: rtl/pause_dim_timer.sv
// Saturating 32-bit idle counter that raises the burn-in dim flag.
module pause_dim_timer
  import pause_sequencer_pkg::*;
#(
  parameter int unsigned DIM_CYCLES = DIM_CYCLES_DEFAULT
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic count_en,
  input  logic clear,
  input  logic hold,
  output logic dim
);

  localparam logic [31:0] LIMIT = 32'(DIM_CYCLES);

  logic [31:0] count_q, count_d;
  logic        dim_q, dim_d;

  always_comb begin
    count_d = '0;
    if (count_en && !clear) begin
      count_d = (count_q >= LIMIT) ? LIMIT : count_q + 32'd1;
    end

    // Flag follows the next count so it rises on the edge the limit is reached
    dim_d = 1'b0;
    if (clear) begin
      dim_d = 1'b0;
    end else if (hold) begin
      dim_d = dim_q;
    end else begin
      dim_d = (count_d >= LIMIT);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      count_q <= '0;
      dim_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dim_q   <= dim_d;
    end
  end

  assign dim = dim_q;

endmodule

// File: rtl/pause_sequencer.sv
// Collects pause requests, halts the CPU on vblank boundaries and grants
// requesters once the halt is acknowledged.
module pause_sequencer
  import pause_sequencer_pkg::*;
#(
  parameter int          NREQ       = 4,
  parameter int unsigned DIM_CYCLES = DIM_CYCLES_DEFAULT
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            vblank,
  input  logic            halt_ack,
  input  logic            dim_en,
  output logic            halt_req,
  output logic [NREQ-1:0] grant,
  output logic            paused,
  output logic            dim
);

  state_e          state_q, state_d;
  logic            vblank_d_q;
  logic            halt_req_q, halt_req_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            paused_q, paused_d;

  logic vbl_edge;
  logic any_req;

  assign vbl_edge = vblank & ~vblank_d_q;
  assign any_req  = |req;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:        if (any_req) state_d = WAIT_VBL;
      // Withdrawal takes priority over a coincident vblank edge
      WAIT_VBL: begin
        if (!any_req)      state_d = RUN;
        else if (vbl_edge) state_d = HALTING;
      end
      HALTING:    if (halt_ack) state_d = PAUSED;
      PAUSED:     if (!any_req) state_d = RESUME_VBL;
      RESUME_VBL: begin
        if (any_req)       state_d = PAUSED;
        else if (vbl_edge) state_d = RUN;
      end
      default:    state_d = RUN;
    endcase

    // The CPU stays halted from HALTING until RESUME_VBL leaves for RUN
    halt_req_d = (state_d == HALTING) || (state_d == PAUSED) ||
                 (state_d == RESUME_VBL);
    paused_d   = (state_d == PAUSED);
    grant_d    = (state_d == PAUSED) ? req : '0;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= RUN;
      vblank_d_q <= 1'b0;
      halt_req_q <= 1'b0;
      grant_q    <= '0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      vblank_d_q <= vblank;
      halt_req_q <= halt_req_d;
      grant_q    <= grant_d;
      paused_q   <= paused_d;
    end
  end

  pause_dim_timer #(
    .DIM_CYCLES(DIM_CYCLES)
  ) u_timer (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .count_en(dim_en && (state_q == PAUSED)),
    .clear   (!dim_en || (state_d == RUN)),
    .hold    (state_q == RESUME_VBL),
    .dim     (dim)
  );

  assign halt_req = halt_req_q;
  assign grant    = grant_q;
  assign paused   = paused_q;

endmodule

// File: tb/tb_pause_sequencer.sv
// Directed bench for pause_sequencer with a short dim interval.
module tb_pause_sequencer;
  import pause_sequencer_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       vblank;
  logic       halt_ack;
  logic       dim_en;
  logic       halt_req;
  logic [3:0] grant;
  logic       paused;
  logic       dim;

  int total = 0;
  int bad   = 0;

  pause_sequencer #(
    .NREQ      (4),
    .DIM_CYCLES(50)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (req),
    .vblank  (vblank),
    .halt_ack(halt_ack),
    .dim_en  (dim_en),
    .halt_req(halt_req),
    .grant   (grant),
    .paused  (paused),
    .dim     (dim)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; req = 4'b0000; vblank = 1'b0; halt_ack = 1'b0; dim_en = 1'b0;
    tick(); tick();
    chk("rst_halt_req", 32'(halt_req), 32'd0);
    chk("rst_grant",    32'(grant),    32'd0);
    chk("rst_paused",   32'(paused),   32'd0);
    chk("rst_dim",      32'(dim),      32'd0);
    reset_n = 1'b1;
    tick();

    // Pause entry
    req = 4'b0001;
    tick();
    chk("t1_state_wait", 32'(dut.state_q), 32'(WAIT_VBL));
    repeat (20) tick();
    chk("t1_no_halt_before_vbl", 32'(halt_req), 32'd0);
    vblank = 1'b1;
    tick();
    chk("t1_halt_req_on_edge", 32'(halt_req), 32'd1);
    chk("t1_not_paused_yet",   32'(paused),   32'd0);
    tick();
    vblank = 1'b0;
    tick();
    chk("t1_still_halting", 32'(paused), 32'd0);
    halt_ack = 1'b1;
    tick();
    chk("t1_paused", 32'(paused),   32'd1);
    chk("t1_grant",  32'(grant),    32'h1);
    chk("t1_halt",   32'(halt_req), 32'd1);

    // Resume re-request
    req = 4'b0000;
    tick();
    chk("t3_resume_paused", 32'(paused),   32'd0);
    chk("t3_resume_grant",  32'(grant),    32'd0);
    chk("t3_resume_halt",   32'(halt_req), 32'd1);
    tick();
    req = 4'b0100;
    tick();
    chk("t3_repause_paused", 32'(paused),   32'd1);
    chk("t3_repause_grant",  32'(grant),    32'h4);
    chk("t3_repause_halt",   32'(halt_req), 32'd1);
    req = 4'b0000;
    tick();
    chk("t3_resume_again", 32'(dut.state_q), 32'(RESUME_VBL));
    vblank = 1'b1;
    tick();
    chk("t3_run_halt_clear", 32'(halt_req),     32'd0);
    chk("t3_run_state",      32'(dut.state_q),  32'(RUN));
    vblank = 1'b0; halt_ack = 1'b0;
    tick();

    // Withdrawal in WAIT_VBL, with vblank already high on entry
    vblank = 1'b1;
    tick();
    req = 4'b0010;
    tick();
    tick();
    chk("t2_no_edge_when_high", 32'(halt_req), 32'd0);
    req = 4'b0000;
    tick();
    chk("t2_state_run", 32'(dut.state_q), 32'(RUN));
    chk("t2_halt",      32'(halt_req),    32'd0);
    chk("t2_grant",     32'(grant),       32'd0);
    chk("t2_paused",    32'(paused),      32'd0);
    vblank = 1'b0;
    tick();

    // Withdrawal coincident with a vblank edge
    req = 4'b0001;
    tick();
    req = 4'b0000; vblank = 1'b1;
    tick();
    chk("tie_halt",  32'(halt_req),    32'd0);
    chk("tie_state", 32'(dut.state_q), 32'(RUN));
    vblank = 1'b0;
    tick();

    // Dim timer
    dim_en = 1'b1; req = 4'b0001;
    tick();
    vblank = 1'b1;
    tick();
    vblank = 1'b0; halt_ack = 1'b1;
    tick();
    chk("t4_paused", 32'(paused), 32'd1);
    repeat (49) tick();
    chk("t4_dim_before", 32'(dim), 32'd0);
    tick();
    chk("t4_dim_at_50", 32'(dim), 32'd1);
    dim_en = 1'b0;
    tick();
    chk("t4_dim_drop", 32'(dim), 32'd0);
    dim_en = 1'b1;
    tick();
    chk("t4_timer_cleared", 32'(dim), 32'd0);
    repeat (48) tick();
    chk("t4_dim_before2", 32'(dim), 32'd0);
    tick();
    chk("t4_dim_again", 32'(dim), 32'd1);

    // Reset mid-pause
    reset_n = 1'b0;
    tick();
    chk("t5_halt",  32'(halt_req),    32'd0);
    chk("t5_grant", 32'(grant),       32'd0);
    chk("t5_dim",   32'(dim),         32'd0);
    chk("t5_state", 32'(dut.state_q), 32'(RUN));
    reset_n = 1'b1; halt_ack = 1'b0; req = 4'b0000; dim_en = 1'b0;
    tick();

    // Late ack after request dropped in HALTING
    req = 4'b0001;
    tick();
    vblank = 1'b1;
    tick();
    chk("t6_halting", 32'(halt_req), 32'd1);
    vblank = 1'b0; req = 4'b0000;
    tick();
    chk("t6_hold_halt", 32'(halt_req), 32'd1);
    chk("t6_not_paused", 32'(paused), 32'd0);
    halt_ack = 1'b1;
    tick();
    chk("t6_paused", 32'(paused), 32'd1);
    chk("t6_grant",  32'(grant),  32'd0);
    tick();
    chk("t6_resume_paused", 32'(paused),   32'd0);
    chk("t6_resume_halt",   32'(halt_req), 32'd1);
    halt_ack = 1'b0;
    tick();
    chk("t6_wait_vbl_halt", 32'(halt_req), 32'd1);
    vblank = 1'b1;
    tick();
    chk("t6_run_halt", 32'(halt_req), 32'd0);
    vblank = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
